// File: rtl/multichannel_sample_window.sv
// Per-channel circular sample history with saturating fill count and running
// window sum. One write per cycle, one clear per cycle, and a registered
// random-access read port that observes state from before same-cycle updates.
module multichannel_sample_window #(
    parameter int unsigned NUM_CHANNELS = 7,
    parameter int unsigned SAMPLE_WIDTH = 8,
    parameter int unsigned DEPTH        = 10,
    localparam int unsigned CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int unsigned TAP_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned SUM_W = SAMPLE_WIDTH + CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_channel,
    input  logic [SAMPLE_WIDTH-1:0] wr_data,
    output logic                    wr_err,
    input  logic                    clr_en,
    input  logic [CH_W-1:0]         clr_channel,
    input  logic                    rd_en,
    input  logic [CH_W-1:0]         rd_channel,
    input  logic [TAP_W-1:0]        rd_tap,
    output logic                    rd_valid,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0]        rd_count,
    output logic [SUM_W-1:0]        rd_sum,
    output logic                    rd_err
);

    // Channel count at one extra bit so the range check works for any NUM_CHANNELS.
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CHANNELS);
    localparam int unsigned   ADDR_W   = TAP_W + 1;

    logic [TAP_W-1:0]        wptr_q  [NUM_CHANNELS];
    logic [CNT_W-1:0]        count_q [NUM_CHANNELS];
    logic [SUM_W-1:0]        sum_q   [NUM_CHANNELS];
    logic [SAMPLE_WIDTH-1:0] mem     [NUM_CHANNELS][DEPTH];

    logic                    wr_ok;
    logic                    clr_ok;
    logic                    same_clr;
    logic [CH_W-1:0]         wr_idx;
    logic [TAP_W-1:0]        base_wptr;
    logic [CNT_W-1:0]        base_count;
    logic [SUM_W-1:0]        base_sum;
    logic [SAMPLE_WIDTH-1:0] evicted;
    logic [TAP_W-1:0]        next_wptr;
    logic [CNT_W-1:0]        next_count;
    logic [SUM_W-1:0]        next_sum;

    logic                    rd_ch_ok;
    logic                    tap_ok;
    logic [CH_W-1:0]         rd_idx;
    logic [CNT_W-1:0]        rd_cnt_cur;
    logic [SUM_W-1:0]        rd_sum_cur;
    logic [TAP_W-1:0]        tap_eff;
    logic [ADDR_W-1:0]       addr_ext;
    logic [TAP_W-1:0]        rd_addr;

    // Write-side next state; a same-channel clear zeroes the base before the write applies.
    always_comb begin
        wr_ok      = wr_en && ({1'b0, wr_channel} < NUM_CH_L);
        clr_ok     = clr_en && ({1'b0, clr_channel} < NUM_CH_L);
        same_clr   = clr_ok && (clr_channel == wr_channel);
        wr_idx     = wr_ok ? wr_channel : '0;
        base_wptr  = same_clr ? '0 : wptr_q[wr_idx];
        base_count = same_clr ? '0 : count_q[wr_idx];
        base_sum   = same_clr ? '0 : sum_q[wr_idx];
        evicted    = mem[wr_idx][base_wptr];
        next_wptr  = (base_wptr == TAP_W'(DEPTH - 1)) ? '0 : base_wptr + TAP_W'(1);
        next_count = base_count;
        next_sum   = base_sum;
        if (base_count < CNT_W'(DEPTH)) begin
            next_count = base_count + CNT_W'(1);
            next_sum   = base_sum + SUM_W'(wr_data);
        end else begin
            next_sum   = base_sum + SUM_W'(wr_data) - SUM_W'(evicted);
        end
    end

    // Read-side address: (wptr - 1 - tap) mod DEPTH, computed without going negative.
    always_comb begin
        rd_ch_ok   = {1'b0, rd_channel} < NUM_CH_L;
        rd_idx     = rd_ch_ok ? rd_channel : '0;
        rd_cnt_cur = count_q[rd_idx];
        rd_sum_cur = sum_q[rd_idx];
        tap_ok     = rd_ch_ok && (32'(rd_tap) < 32'(rd_cnt_cur)) && (32'(rd_tap) < DEPTH);
        tap_eff    = tap_ok ? rd_tap : '0;
        addr_ext   = ADDR_W'(wptr_q[rd_idx]) + ADDR_W'(DEPTH - 1) - ADDR_W'(tap_eff);
        if (addr_ext >= ADDR_W'(DEPTH)) begin
            addr_ext = addr_ext - ADDR_W'(DEPTH);
        end
        rd_addr    = TAP_W'(addr_ext);
    end

    // Per-channel pointer, fill count and window sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                wptr_q[c]  <= '0;
                count_q[c] <= '0;
                sum_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
                if (clr_ok && (clr_channel == CH_W'(c))) begin
                    wptr_q[c]  <= '0;
                    count_q[c] <= '0;
                    sum_q[c]   <= '0;
                end
                if (wr_ok && (wr_channel == CH_W'(c))) begin
                    wptr_q[c]  <= next_wptr;
                    count_q[c] <= next_count;
                    sum_q[c]   <= next_sum;
                end
            end
        end
    end

    // Sample storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx][base_wptr] <= wr_data;
        end
    end

    // Out-of-range write flag, one cycle after the offending strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ch_in_range(wr_channel);
        end
    end

    function automatic logic wr_ch_in_range(input logic [CH_W-1:0] ch);
        return {1'b0, ch} < NUM_CH_L;
    endfunction

    // Registered read response; data/count/sum hold when no read is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
            rd_count <= '0;
            rd_sum   <= '0;
        end else if (rd_en) begin
            rd_valid <= 1'b1;
            rd_err   <= !tap_ok;
            rd_data  <= tap_ok ? mem[rd_idx][rd_addr] : '0;
            rd_count <= rd_ch_ok ? rd_cnt_cur : '0;
            rd_sum   <= rd_ch_ok ? rd_sum_cur : '0;
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multichannel_sample_window.sv
// Directed bench for multichannel_sample_window (7 channels, 8-bit, depth 10).
module tb_multichannel_sample_window;

    localparam int unsigned CH_W  = 3;
    localparam int unsigned TAP_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SUM_W = 12;

    logic             clk;
    logic             reset;
    logic             wr_en;
    logic [CH_W-1:0]  wr_channel;
    logic [7:0]       wr_data;
    logic             wr_err;
    logic             clr_en;
    logic [CH_W-1:0]  clr_channel;
    logic             rd_en;
    logic [CH_W-1:0]  rd_channel;
    logic [TAP_W-1:0] rd_tap;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic [CNT_W-1:0] rd_count;
    logic [SUM_W-1:0] rd_sum;
    logic             rd_err;

    int n_pass;
    int n_total;

    multichannel_sample_window #(
        .NUM_CHANNELS(7), .SAMPLE_WIDTH(8), .DEPTH(10)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_channel(wr_channel), .wr_data(wr_data), .wr_err(wr_err),
        .clr_en(clr_en), .clr_channel(clr_channel),
        .rd_en(rd_en), .rd_channel(rd_channel), .rd_tap(rd_tap),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_count(rd_count),
        .rd_sum(rd_sum), .rd_err(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus at the falling edge, return just after the rising edge.
    task automatic drive(input logic we, input logic [CH_W-1:0] wch, input logic [7:0] wd,
                         input logic ce, input logic [CH_W-1:0] cch,
                         input logic re, input logic [CH_W-1:0] rch, input logic [TAP_W-1:0] tap);
        @(negedge clk);
        wr_en = we; wr_channel = wch; wr_data = wd;
        clr_en = ce; clr_channel = cch;
        rd_en = re; rd_channel = rch; rd_tap = tap;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %0b want 0", rd_valid); else n_pass++;
        n_total++; if (wr_err !== 1'b0) $display("FAIL reset_wr_err got %0b want 0", wr_err); else n_pass++;
        n_total++; if ({rd_data, rd_count, rd_sum, rd_err} !== '0)
            $display("FAIL reset_outputs got data=%0d cnt=%0d sum=%0d err=%0b want all 0", rd_data, rd_count, rd_sum, rd_err);
            else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd0, 4'd0);
        n_total++; if (rd_valid !== 1'b1) $display("FAIL empty_read_valid got %0b want 1", rd_valid); else n_pass++;
        n_total++; if (rd_err !== 1'b1) $display("FAIL empty_read_err got %0b want 1", rd_err); else n_pass++;
        n_total++; if ({rd_data, rd_count, rd_sum} !== '0)
            $display("FAIL empty_read_fields got data=%0d cnt=%0d sum=%0d want 0/0/0", rd_data, rd_count, rd_sum);
            else n_pass++;
        idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [4];
        exp_d[0] = 8'd3; exp_d[1] = 8'd2; exp_d[2] = 8'd1; exp_d[3] = 8'd0;
        for (int i = 1; i <= 3; i++) drive(1'b1, 3'd2, 8'(i), 1'b0, 3'd0, 1'b0, 3'd0, 4'd0);
        for (int t = 0; t < 4; t++) begin
            drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd2, 4'(t));
            n_total++; if (rd_valid !== 1'b1) $display("FAIL b2b_valid tap%0d got %0b want 1", t, rd_valid); else n_pass++;
            n_total++; if (rd_data !== exp_d[t]) $display("FAIL b2b_data tap%0d got %0d want %0d", t, rd_data, exp_d[t]); else n_pass++;
            n_total++; if (rd_err !== (t == 3)) $display("FAIL b2b_err tap%0d got %0b want %0b", t, rd_err, (t == 3)); else n_pass++;
            n_total++; if (rd_count !== 4'd3 || rd_sum !== 12'd6)
                $display("FAIL b2b_cnt_sum tap%0d got cnt=%0d sum=%0d want 3/6", t, rd_count, rd_sum); else n_pass++;
        end
        idle();
        n_total++; if (rd_valid !== 1'b0 || rd_err !== 1'b0) $display("FAIL idle_after_read got valid=%0b err=%0b want 0/0", rd_valid, rd_err); else n_pass++;
        n_total++; if (rd_count !== 4'd3 || rd_sum !== 12'd6) $display("FAIL idle_hold got cnt=%0d sum=%0d want 3/6", rd_count, rd_sum); else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 12; i++) drive(1'b1, 3'd0, 8'(i), 1'b0, 3'd0, 1'b0, 3'd0, 4'd0);
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd0, 4'd0);
        n_total++; if (rd_data !== 8'd12) $display("FAIL wrap_tap0 got %0d want 12", rd_data); else n_pass++;
        n_total++; if (rd_count !== 4'd10 || rd_sum !== 12'd75) $display("FAIL wrap_cnt_sum got cnt=%0d sum=%0d want 10/75", rd_count, rd_sum); else n_pass++;
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd0, 4'd9);
        n_total++; if (rd_data !== 8'd3 || rd_err !== 1'b0) $display("FAIL wrap_tap9 got data=%0d err=%0b want 3/0", rd_data, rd_err); else n_pass++;
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd0, 4'd10);
        n_total++; if (rd_err !== 1'b1 || rd_data !== 8'd0) $display("FAIL wrap_tap10 got data=%0d err=%0b want 0/1", rd_data, rd_err); else n_pass++;
        idle();
    endtask

    task automatic test_clear_write();
        drive(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 1'b1, 3'd0, 4'd0);
        n_total++; if (rd_data !== 8'd12 || rd_count !== 4'd10 || rd_sum !== 12'd75)
            $display("FAIL clrwr_prestate got data=%0d cnt=%0d sum=%0d want 12/10/75", rd_data, rd_count, rd_sum); else n_pass++;
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd0, 4'd0);
        n_total++; if (rd_data !== 8'hFF || rd_count !== 4'd1 || rd_sum !== 12'd255 || rd_err !== 1'b0)
            $display("FAIL clrwr_post got data=%0d cnt=%0d sum=%0d err=%0b want 255/1/255/0", rd_data, rd_count, rd_sum, rd_err); else n_pass++;
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd0, 4'd1);
        n_total++; if (rd_err !== 1'b1) $display("FAIL clrwr_tap1_err got %0b want 1", rd_err); else n_pass++;
        // Clear ch2 while writing ch0: both must land.
        drive(1'b1, 3'd0, 8'h10, 1'b1, 3'd2, 1'b0, 3'd0, 4'd0);
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd2, 4'd0);
        n_total++; if (rd_count !== 4'd0 || rd_sum !== 12'd0 || rd_err !== 1'b1)
            $display("FAIL split_clr_ch2 got cnt=%0d sum=%0d err=%0b want 0/0/1", rd_count, rd_sum, rd_err); else n_pass++;
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd0, 4'd0);
        n_total++; if (rd_data !== 8'h10 || rd_count !== 4'd2 || rd_sum !== 12'd271)
            $display("FAIL split_wr_ch0 got data=%0d cnt=%0d sum=%0d want 16/2/271", rd_data, rd_count, rd_sum); else n_pass++;
        idle();
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 3'd7, 8'h55, 1'b1, 3'd7, 1'b0, 3'd0, 4'd0);
        n_total++; if (wr_err !== 1'b1) $display("FAIL wr_err_pulse got %0b want 1", wr_err); else n_pass++;
        idle();
        n_total++; if (wr_err !== 1'b0) $display("FAIL wr_err_clear got %0b want 0", wr_err); else n_pass++;
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd0, 4'd0);
        n_total++; if (rd_count !== 4'd2 || rd_sum !== 12'd271) $display("FAIL oor_ch0_unchanged got cnt=%0d sum=%0d want 2/271", rd_count, rd_sum); else n_pass++;
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd2, 4'd0);
        n_total++; if (rd_count !== 4'd0) $display("FAIL oor_ch2_unchanged got cnt=%0d want 0", rd_count); else n_pass++;
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd7, 4'd0);
        n_total++; if (rd_err !== 1'b1 || {rd_data, rd_count, rd_sum} !== '0)
            $display("FAIL oor_read got err=%0b data=%0d cnt=%0d sum=%0d want 1/0/0/0", rd_err, rd_data, rd_count, rd_sum); else n_pass++;
        idle();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 3'd1, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0);
            if (i < 4) drive(1'b1, 3'd3, 8'(i + 1), 1'b0, 3'd0, 1'b0, 3'd0, 4'd0);
        end
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd1, 4'd0);
        n_total++; if (rd_sum !== 12'd2550 || rd_count !== 4'd10 || rd_data !== 8'hFF)
            $display("FAIL sat_ch1 got data=%0d cnt=%0d sum=%0d want 255/10/2550", rd_data, rd_count, rd_sum); else n_pass++;
        drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'd3, 4'd0);
        n_total++; if (rd_data !== 8'd4 || rd_count !== 4'd4 || rd_sum !== 12'd10)
            $display("FAIL sat_ch3_indep got data=%0d cnt=%0d sum=%0d want 4/4/10", rd_data, rd_count, rd_sum); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        reset = 1'b1; rd_en = 1'b1; rd_channel = 3'd1; rd_tap = 4'd0;
        @(posedge clk); #1;
        n_total++; if (rd_valid !== 1'b0) $display("FAIL mid_reset_drop got %0b want 0", rd_valid); else n_pass++;
        @(negedge clk);
        reset = 1'b0; rd_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 1'b1, 3'(c), 4'd0);
            n_total++; if (rd_count !== 4'd0 || rd_sum !== 12'd0 || rd_err !== 1'b1)
                $display("FAIL mid_reset_ch%0d got cnt=%0d sum=%0d err=%0b want 0/0/1", c, rd_count, rd_sum, rd_err); else n_pass++;
        end
        idle();
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1;
        wr_en = 1'b0; wr_channel = '0; wr_data = '0;
        clr_en = 1'b0; clr_channel = '0;
        rd_en = 1'b0; rd_channel = '0; rd_tap = '0;
        test_reset();
        test_back_to_back();
        test_wrap();
        test_clear_write();
        test_out_of_range();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multichannel_sample_window.md
Name: multichannel_sample_window

Overview:
Parametrised per-channel sample history buffer for the tile's acquisition path. Each channel keeps a DEPTH-deep circular window of its most recent samples, plus a saturating fill count and a running window sum for moving-average use. Writes target one channel per cycle. A registered random-access read port returns any tap of any channel together with that channel's count and sum.

Parameters:
NUM_CHANNELS, 7, number of independent channels (>=1)
SAMPLE_WIDTH, 8, bits per sample
DEPTH, 10, samples retained per channel (>=2)
Derived (localparam): CH_W = max(1,clog2(NUM_CHANNELS)); TAP_W = clog2(DEPTH); CNT_W = clog2(DEPTH+1); SUM_W = SAMPLE_WIDTH+CNT_W

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe
wr_channel  in  CH_W  target channel of write
wr_data  in  SAMPLE_WIDTH  sample to store
wr_err  out  1  one-cycle pulse: write ignored, channel out of range
clr_en  in  1  clear strobe
clr_channel  in  CH_W  channel to clear
rd_en  in  1  read request
rd_channel  in  CH_W  channel to read
rd_tap  in  TAP_W  0 = newest sample, 1 = previous, ...
rd_valid  out  1  read response valid, one-cycle pulse
rd_data  out  SAMPLE_WIDTH  requested sample
rd_count  out  CNT_W  fill count of the read channel
rd_sum  out  SUM_W  window sum of the read channel
rd_err  out  1  tap >= count, or channel out of range

Behaviour:
- Reset: clk and reset are as decided (synchronous, active-high reset; clock clk). All wptr, count and sum are 0. rd_valid, rd_data, rd_count, rd_sum, rd_err and wr_err are 0. Sample storage is not reset.
- Per-channel state: wptr (0..DEPTH-1), count (0..DEPTH), sum (SUM_W bits), mem[DEPTH].
- Write, when wr_en and wr_channel < NUM_CHANNELS:
  - mem[wptr] <= wr_data.
  - wptr <= (wptr==DEPTH-1) ? 0 : wptr+1.
  - If count < DEPTH: count+1 and sum+wr_data.
  - Else: sum + wr_data - mem[wptr], where mem[wptr] is the evicted oldest sample. count stays DEPTH.
- Sum never overflows because SUM_W covers DEPTH*max sample. Unsigned arithmetic throughout.
- Write with wr_channel >= NUM_CHANNELS: no state change; wr_err=1 in the next cycle. Otherwise wr_err=0.
- Clear, when clr_en and clr_channel valid: that channel's wptr, count and sum go to 0. mem is untouched. An out-of-range clr_channel is ignored silently.
- Clear and write to the same channel in the same cycle: the clear applies first, then the write. Result: count=1, sum=wr_data, wptr=1, mem[0]=wr_data.
- Clear and write to different channels in the same cycle: both take effect.
- Read: latency 1. The cycle after rd_en, rd_valid=1 and outputs reflect state as it was before any same-cycle write or clear (read-before-write).
  - Address = (wptr - 1 - rd_tap) mod DEPTH.
  - rd_count and rd_sum are the channel's pre-update values.
- Read error: if rd_tap >= count, rd_tap >= DEPTH, or rd_channel out of range, then rd_err=1 and rd_data=0. If the channel is out of range, rd_count=0 and rd_sum=0 as well.
- When rd_en=0: rd_valid=0 next cycle; rd_data, rd_count and rd_sum hold their last values; rd_err=0.
- Back-to-back reads every cycle are supported; no backpressure.
- Reset mid-operation: a pending read response is dropped (rd_valid=0), and all windows are emptied.

Test Plan:
- Reset, then read ch0 tap0 -> next cycle rd_valid=1, rd_err=1, rd_data=0, rd_count=0, rd_sum=0.
- Write ch2 values 1..3 in order, then read ch2 taps 0, 1, 2 back-to-back -> rd_data 3, 2, 1 on consecutive cycles; rd_count=3, rd_sum=6; tap 3 -> rd_err=1.
- Write ch0 values 1..12 (DEPTH=10) -> rd_count=10, rd_sum=75 (3..12); tap0=12, tap9=3 (wrap-around verified).
- Full ch0 (sum 75): in one cycle clr_en ch0 + wr_en ch0 data 0xFF + rd_en ch0 tap0 -> response shows pre-state (12, count 10, sum 75); the following read shows count=1, sum=255, tap0=0xFF.
- wr_channel=7 (out of range, NUM_CHANNELS=7) -> wr_err pulses 1 cycle, and all channel counts are unchanged.
- Write ch1 = 0xFF eleven times -> rd_sum=2550 with no overflow (SUM_W=12); ch3 is written concurrently and stays independent; a mid-stream reset -> all counts read 0.
